sync_fifo_rr_drain: RTL and testbench
=====================================

# sync_fifo_rr_drain

Round-robin drain controller that shares one downstream valid/ready stream among `NUM_PORTS` sync FIFOs. It selects a non-empty FIFO and pops up to `MAX_BURST` words from it before rotating priority. Each popped word is registered into a single output holding stage, tagged with its source port. It sits between a bank of sync FIFOs (first-word-fall-through: `data_out` valid whenever `!empty`, `rd_en` pops) and a single consumer.

## Interface
- `DATA_WIDTH`, 8: word width.
- `NUM_PORTS`, 4: number of FIFOs drained; ≥2.
- `MAX_BURST`, 4: maximum consecutive pops from one FIFO per grant; ≥1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  NUM_PORTS  per-FIFO `empty`.
- `fifo_data`  in  NUM_PORTS*DATA_WIDTH  per-FIFO `data_out`; port i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `fifo_rd_en`  out  NUM_PORTS  per-FIFO pop strobe; zero or one-hot.
- `out_valid`  out  1  output holding stage full.
- `out_ready`  in  1  consumer accepts the word when `out_valid && out_ready`.
- `out_data`  out  DATA_WIDTH  held word.
- `out_src`  out  $clog2(NUM_PORTS)  index of the FIFO that supplied `out_data`.

## Operation
- `can_load = !out_valid || out_ready`. No pop happens unless `can_load`.
- Priority pointer `ptr`, reset to `NUM_PORTS-1`, so port 0 wins first. Pick is the first port with `!fifo_empty` searching `ptr+1, ptr+2, …` modulo `NUM_PORTS`.
- States:
  - IDLE: if any FIFO is non-empty and `can_load`, pop the picked port `p` this cycle and set `gnt<=p`, `cnt<=1`. Go to BURST if `MAX_BURST>1`; otherwise set `ptr<=p` and stay in IDLE. If nothing is pickable or `!can_load`, stay in IDLE with no pop.
  - BURST:
    - If `fifo_empty[gnt]`: no pop; `ptr<=gnt`; go to IDLE. This costs one bubble cycle.
    - Else if `can_load`: pop `gnt`, `cnt<=cnt+1`. If this pop is the `MAX_BURST`-th word (`cnt==MAX_BURST-1`), set `ptr<=gnt` and go to IDLE.
    - Else: hold.
- A pop loads `out_data<=fifo_data[p]`, `out_src<=p`, `out_valid<=1`.
- If there is no pop and `out_ready` is high, `out_valid<=0`.
- Simultaneous pop and consume keeps `out_valid=1` with the new word. Full throughput is one word per cycle.
- `fifo_rd_en` is never asserted to an empty FIFO and never has more than one bit set.
- While `out_valid && !out_ready`, `out_data` and `out_src` are stable.
- `cnt` width is $clog2(MAX_BURST+1); it never exceeds `MAX_BURST`.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, state IDLE, `ptr=NUM_PORTS-1`, `cnt=0`, `gnt=0`.
- `fifo_rd_en` is forced to 0 during any cycle with `rst` high.
- Reset mid-burst abandons the burst and drops the held word. The word already popped and held is lost; this is accepted.
- `fifo_rd_en` is combinational from `fifo_empty`, `out_ready`, and state. This includes a combinational path from `out_ready` to `fifo_rd_en`.
- Latency: a word popped in cycle n appears with `out_valid` in cycle n+1.
- An empty-to-non-empty FIFO in IDLE is popped in the same cycle it is seen.

## Structure
- Shared package `sync_fifo_pkg`:
  - `typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t`.
  - Helper function for the port-index width.
- Sub-module `rr_priority_pick`: combinational round-robin picker.
  - Inputs: `req[NUM_PORTS]`, `ptr`.
  - Outputs: `found`, `idx`.
  - It is reused by later arbiters.
- Top module holds the FSM, counter, pointer, and output stage.

## Test plan
- Single source: FIFO1 holds 0x11,0x22,0x33, `out_ready=1` → `out_data` 0x11,0x22,0x33 on consecutive cycles starting one cycle after first pop, all with `out_src=1`.
- Fairness: all four FIFOs hold 6 words, `MAX_BURST=4` → source order 0×4, 1×4, 2×4, 3×4, 0×2, 1×2, 2×2, 3×2.
- Backpressure: `out_ready=0` for 3 cycles while `out_valid=1` → `out_data`/`out_src` unchanged and `fifo_rd_en=0` throughout; the next word follows on the cycle after `out_ready` rises.
- Early burst end: FIFO2 holds 2 words, FIFO3 holds 5, `ptr=1` → 2 words from port 2, one bubble cycle, then 4 from port 3, then 1 more from port 3.
- Reset mid-burst: `rst` pulsed after 2 pops from port 1 → next cycle `out_valid=0`; with all FIFOs non-empty, the next grant is port 0.
- Safety (random, 10k cycles): `fifo_rd_en` is always zero or one-hot and never hits an empty FIFO; the per-port output sequence equals the per-port write order.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the sync-FIFO drain arbiters.
package sync_fifo_pkg;

  typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;

  function automatic int port_idx_width(input int num_ports);
    return (num_ports > 1) ? $clog2(num_ports) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first requesting port after ptr, wrapping modulo NUM_PORTS.
// Zero latency; no state, so no backpressure of its own.
module rr_priority_pick
  import sync_fifo_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IW        = port_idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        ptr,
  output logic                 found,
  output logic [IW-1:0]        idx
);

  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    // Scan farthest-first so the nearest requester after ptr overwrites the rest.
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % NUM_PORTS);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sync_fifo_rr_drain.sv
// Round-robin burst drain of NUM_PORTS FWFT FIFOs into one registered valid/ready stage.
// Word popped in cycle n is valid in n+1; no pop while the held word is stalled.
module sync_fifo_rr_drain
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PORTS  = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            fifo_empty,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_PORTS-1:0]            fifo_rd_en,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_PORTS)-1:0]    out_src
);

  localparam int IW = port_idx_width(NUM_PORTS);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t            state, state_nxt;
  logic [IW-1:0]         ptr, ptr_nxt;
  logic [IW-1:0]         gnt, gnt_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [IW-1:0]         pick_idx, pop_idx;
  logic                  pick_found, can_load, pop;
  logic [DATA_WIDTH-1:0] port_dat [NUM_PORTS];

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
    assign port_dat[i] = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign can_load = !out_valid || out_ready;

  rr_priority_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_pick (
    .req   (~fifo_empty),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    cnt_nxt   = cnt;
    pop       = 1'b0;
    pop_idx   = gnt;
    case (state)
      ARB_IDLE: begin
        if (pick_found && can_load) begin
          pop     = 1'b1;
          pop_idx = pick_idx;
          gnt_nxt = pick_idx;
          cnt_nxt = CW'(1);
          if (MAX_BURST > 1) state_nxt = ARB_BURST;
          else               ptr_nxt   = pick_idx;
        end
      end
      ARB_BURST: begin
        // An emptied grantee ends the burst with one bubble cycle.
        if (fifo_empty[gnt]) begin
          ptr_nxt   = gnt;
          state_nxt = ARB_IDLE;
        end else if (can_load) begin
          pop     = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt == CW'(MAX_BURST - 1)) begin
            ptr_nxt   = gnt;
            state_nxt = ARB_IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    fifo_rd_en = '0;
    if (pop && !rst) fifo_rd_en[pop_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB_IDLE;
      ptr   <= IW'(NUM_PORTS - 1);
      gnt   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_data  <= port_dat[pop_idx];
      out_src   <= pop_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_rr_drain.sv
// Directed and random bench for sync_fifo_rr_drain with queue-based FIFO and output-stage model.
module tb_sync_fifo_rr_drain;

  localparam int DW = 8;
  localparam int NP = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          out_ready = 1'b0;
  logic [NP-1:0] fifo_empty;
  logic [NP*DW-1:0] fifo_data;
  logic [NP-1:0] fifo_rd_en;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    out_src;

  sync_fifo_rr_drain #(
    .DATA_WIDTH (DW),
    .NUM_PORTS  (NP),
    .MAX_BURST  (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_src    (out_src)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] q [NP][$];
  int         cons[$];
  int         exp_list[$];
  logic       exp_valid = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic [1:0] exp_src = 2'd0;
  logic       obs_valid;
  logic [7:0] obs_data;
  logic [1:0] obs_src;
  logic [3:0] obs_rd;
  logic       seq_chk = 1'b0;
  logic [7:0] nxt [NP];
  logic [7:0] wr [NP];
  logic [10:0] vpat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_list(input string name);
    int bad;
    bad = -1;
    tests++;
    for (int i = 0; i < exp_list.size(); i++)
      if (bad < 0 && (i >= cons.size() || cons[i] != exp_list[i])) bad = i;
    if (bad < 0 && cons.size() != exp_list.size()) bad = exp_list.size();
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: entry %0d got 0x%0h expected 0x%0h (%0d entries, expected %0d)", name, bad,
               (bad < cons.size()) ? cons[bad] : -1, (bad < exp_list.size()) ? exp_list[bad] : -1,
               cons.size(), exp_list.size());
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i]         = (q[i].size() == 0);
      fifo_data[i*DW +: DW] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask

  task automatic push(input int p, input logic [7:0] d);
    q[p].push_back(d);
    refresh();
  endtask

  // One clock: compare at negedge, then advance FIFOs and the holding-stage model at posedge.
  task automatic step();
    logic rst_s, rdy_s, popped;
    @(negedge clk);
    obs_valid = out_valid;
    obs_data  = out_data;
    obs_src   = out_src;
    obs_rd    = fifo_rd_en;
    rst_s     = rst;
    rdy_s     = out_ready;
    chk("out_valid", 32'(out_valid), 32'(exp_valid));
    chk("out_data", 32'(out_data), 32'(exp_data));
    chk("out_src", 32'(out_src), 32'(exp_src));
    chk("rd_onehot", 32'($onehot0(fifo_rd_en)), 1);
    chk("rd_empty", 32'(|(fifo_rd_en & fifo_empty)), 0);
    chk("rd_stall", 32'((|fifo_rd_en) && exp_valid && !out_ready), 0);
    chk("rd_rst", 32'(rst && (|fifo_rd_en)), 0);
    if (!rst && out_valid && out_ready) begin
      cons.push_back(int'(out_src) * 256 + int'(out_data));
      if (seq_chk) begin
        chk("port_order", 32'(out_data), 32'(nxt[out_src]));
        nxt[out_src] = nxt[out_src] + 8'd1;
      end
    end
    @(posedge clk);
    if (rst_s) begin
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_src   = 2'd0;
    end else begin
      popped = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (!popped && obs_rd[i] && q[i].size() > 0) begin
          exp_data = q[i].pop_front();
          exp_src  = 2'(i);
          popped   = 1'b1;
        end
      end
      if (popped)     exp_valid = 1'b1;
      else if (rdy_s) exp_valid = 1'b0;
    end
    #1;
    refresh();
  endtask

  initial begin
    refresh();
    repeat (2) @(posedge clk);
    #1;

    // Reset state, with a non-empty FIFO that must not be popped.
    push(0, 8'hAA);
    step();
    chk("reset_valid", 32'(obs_valid), 0);
    chk("reset_data", 32'(obs_data), 0);
    chk("reset_src", 32'(obs_src), 0);
    chk("reset_rd_en", 32'(obs_rd), 0);
    q[0].delete();
    refresh();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) step();

    // Single source on port 1.
    push(1, 8'h11); push(1, 8'h22); push(1, 8'h33);
    step(); chk("single_pop", 32'(obs_rd), 32'(4'b0010));
    step(); chk("single_w0", 32'({obs_valid, obs_src, obs_data}), 32'({1'b1, 2'd1, 8'h11}));
    step(); chk("single_w1", 32'({obs_valid, obs_src, obs_data}), 32'({1'b1, 2'd1, 8'h22}));
    step(); chk("single_w2", 32'({obs_valid, obs_src, obs_data}), 32'({1'b1, 2'd1, 8'h33}));
    chk("single_bubble", 32'(obs_rd), 0);
    step(); chk("single_empty", 32'(obs_valid), 0);

    // Early burst end: pointer now sits on port 1.
    push(2, 8'h21); push(2, 8'h22);
    for (int k = 1; k <= 5; k++) push(3, 8'(8'h30 + k));
    cons.delete();
    vpat = '0;
    for (int i = 0; i < 11; i++) begin
      step();
      vpat[i] = obs_valid;
    end
    chk("early_valid_pattern", 32'(vpat), 32'(11'b00111110110));
    exp_list = '{'h221, 'h222, 'h331, 'h332, 'h333, 'h334, 'h335};
    chk_list("early_order");
    repeat (2) step();

    // Fairness from a fresh reset.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 6; k++) push(p, 8'(p * 16 + k));
    cons.delete();
    repeat (34) step();
    exp_list.delete();
    for (int p = 0; p < NP; p++)
      for (int k = 0; k < 4; k++) exp_list.push_back(p * 256 + p * 16 + k);
    for (int p = 0; p < NP; p++)
      for (int k = 4; k < 6; k++) exp_list.push_back(p * 256 + p * 16 + k);
    chk_list("fairness_order");

    // Backpressure hold.
    push(0, 8'hA1); push(0, 8'hA2); push(0, 8'hA3);
    step(); chk("bp_first_pop", 32'(obs_rd), 32'(4'b0001));
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", 32'({obs_valid, obs_src, obs_data}), 32'({1'b1, 2'd0, 8'hA1}));
      chk("bp_no_pop", 32'(obs_rd), 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_release_pop", 32'(obs_rd), 32'(4'b0001));
    step(); chk("bp_next_word", 32'({obs_valid, obs_src, obs_data}), 32'({1'b1, 2'd0, 8'hA2}));
    repeat (4) step();

    // Reset mid-burst on port 1.
    for (int k = 1; k <= 4; k++) push(1, 8'(8'h50 + k));
    step(); chk("mid_first_grant", 32'(obs_rd), 32'(4'b0010));
    step();
    rst = 1'b1;
    push(0, 8'h61); push(2, 8'h62); push(3, 8'h63);
    step(); chk("mid_rst_rd_en", 32'(obs_rd), 0);
    rst = 1'b0;
    step();
    chk("mid_drop_valid", 32'(obs_valid), 0);
    chk("mid_next_grant", 32'(obs_rd), 32'(4'b0001));
    repeat (14) step();

    // Random traffic and backpressure.
    for (int p = 0; p < NP; p++) begin
      wr[p]  = 8'h00;
      nxt[p] = 8'h00;
    end
    seq_chk = 1'b1;
    cons.delete();
    repeat (10000) begin
      for (int p = 0; p < NP; p++) begin
        if (q[p].size() < 8 && $urandom_range(0, 2) == 0) begin
          push(p, wr[p]);
          wr[p] = wr[p] + 8'd1;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    out_ready = 1'b1;
    repeat (100) step();
    for (int p = 0; p < NP; p++) chk("rand_port_count", 32'(nxt[p]), 32'(wr[p]));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
